// File: rtl/pong_sound_fx.sv
// rtl/pong_sound_fx.sv - square-wave tone bursts for game events, one sample per audio tick
// Tones are sequenced by a small priority FSM; samples go out over a valid/ready handshake.
module pong_sound_fx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int AMPLITUDE    = 8000,
  parameter int PADDLE_HALF  = 50,
  parameter int WALL_HALF    = 100,
  parameter int SCORE_A_HALF = 40,
  parameter int SCORE_B_HALF = 30,
  parameter int PADDLE_DUR   = 4410,
  parameter int WALL_DUR     = 2205,
  parameter int SCORE_DUR    = 8820,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           audioClock,
  input  logic                           paddleHit,
  input  logic                           wallHit,
  input  logic                           scoreEvent,
  output logic signed [SAMPLE_WIDTH-1:0] sampleData,
  output logic                           sampleValid,
  input  logic                           sampleReady,
  output logic                           busy,
  output logic                           overrun
);

  typedef enum logic [2:0] {IDLE, PADDLE, WALL, SCORE_A, SCORE_B} state_t;

  localparam logic signed [SAMPLE_WIDTH-1:0] AMP_FULL = SAMPLE_WIDTH'(AMPLITUDE);
  localparam logic signed [SAMPLE_WIDTH-1:0] AMP_HALF = SAMPLE_WIDTH'(AMPLITUDE / 2);
  localparam logic [CNT_WIDTH-1:0] P_HALF  = CNT_WIDTH'(PADDLE_HALF);
  localparam logic [CNT_WIDTH-1:0] W_HALF  = CNT_WIDTH'(WALL_HALF);
  localparam logic [CNT_WIDTH-1:0] SA_HALF = CNT_WIDTH'(SCORE_A_HALF);
  localparam logic [CNT_WIDTH-1:0] SB_HALF = CNT_WIDTH'(SCORE_B_HALF);
  localparam logic [CNT_WIDTH-1:0] P_DUR   = CNT_WIDTH'(PADDLE_DUR);
  localparam logic [CNT_WIDTH-1:0] W_DUR   = CNT_WIDTH'(WALL_DUR);
  localparam logic [CNT_WIDTH-1:0] S_DUR   = CNT_WIDTH'(SCORE_DUR);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  state_t                         state, state_next, ev_state;
  logic [CNT_WIDTH-1:0]           halfCnt, halfCnt_next, durCnt, durCnt_next;
  logic [CNT_WIDTH-1:0]           ev_dur, cur_half, cur_dur;
  logic                           polarity, polarity_next;
  logic                           audioPrev, tick, accept;
  logic [1:0]                     ev_prio, cur_prio;
  logic signed [SAMPLE_WIDTH-1:0] mag, sample_next;

  assign tick = audioClock & ~audioPrev;
  assign busy = (state != IDLE);

  always_comb begin
    ev_state = IDLE;
    ev_prio  = 2'd0;
    ev_dur   = '0;
    if (scoreEvent) begin
      ev_state = SCORE_A;
      ev_prio  = 2'd3;
      ev_dur   = S_DUR;
    end else if (paddleHit) begin
      ev_state = PADDLE;
      ev_prio  = 2'd2;
      ev_dur   = P_DUR;
    end else if (wallHit) begin
      ev_state = WALL;
      ev_prio  = 2'd1;
      ev_dur   = W_DUR;
    end
  end

  always_comb begin
    cur_prio = 2'd0;
    cur_half = ONE;
    cur_dur  = ONE;
    case (state)
      PADDLE:  begin cur_prio = 2'd2; cur_half = P_HALF;  cur_dur = P_DUR; end
      WALL:    begin cur_prio = 2'd1; cur_half = W_HALF;  cur_dur = W_DUR; end
      SCORE_A: begin cur_prio = 2'd3; cur_half = SA_HALF; cur_dur = S_DUR; end
      SCORE_B: begin cur_prio = 2'd3; cur_half = SB_HALF; cur_dur = S_DUR; end
      default: ;
    endcase
  end

  assign accept = (ev_state != IDLE) && (ev_prio >= cur_prio);

  // Sample reflects pre-tick state; second half of a tone plays at half amplitude.
  always_comb begin
    mag         = (durCnt > (cur_dur >> 1)) ? AMP_FULL : AMP_HALF;
    sample_next = '0;
    if (state != IDLE)
      sample_next = polarity ? mag : -mag;
  end

  always_comb begin
    state_next    = state;
    halfCnt_next  = halfCnt;
    durCnt_next   = durCnt;
    polarity_next = polarity;
    if (accept) begin
      state_next    = ev_state;
      halfCnt_next  = '0;
      polarity_next = 1'b1;
      durCnt_next   = ev_dur;
    end else if (tick && state != IDLE) begin
      if (halfCnt == cur_half - ONE) begin
        halfCnt_next  = '0;
        polarity_next = ~polarity;
      end else begin
        halfCnt_next = halfCnt + ONE;
      end
      if (durCnt == ONE) begin
        case (state)
          SCORE_A: begin
            state_next    = SCORE_B;
            durCnt_next   = S_DUR;
            halfCnt_next  = '0;
            polarity_next = 1'b1;
          end
          default: state_next = IDLE;
        endcase
      end else begin
        durCnt_next = durCnt - ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      halfCnt     <= '0;
      durCnt      <= '0;
      polarity    <= 1'b1;
      audioPrev   <= 1'b0;
      sampleData  <= '0;
      sampleValid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state     <= state_next;
      halfCnt   <= halfCnt_next;
      durCnt    <= durCnt_next;
      polarity  <= polarity_next;
      audioPrev <= audioClock;
      if (tick) begin
        sampleData  <= sample_next;
        sampleValid <= 1'b1;
        if (sampleValid && !sampleReady)
          overrun <= 1'b1;
      end else if (sampleValid && sampleReady) begin
        sampleValid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pong_sound_fx.md
Name: pong_sound_fx

Overview:
- Downstream consumer of the audio clock divider's `audioClock` output.
- Turns single-cycle game events (paddle hit, wall hit, score) into square-wave tone bursts.
- Emits exactly one signed sample per audio-clock rising edge, over a valid/ready handshake, to the audio codec serializer.
- Runs entirely in the 50 MHz system clock domain; `audioClock` is treated as a synchronous level, not as a clock.

Parameters:
SAMPLE_WIDTH, 16, width of signed output sample
AMPLITUDE, 8000, peak magnitude of tone (positive, < 2^(SAMPLE_WIDTH-1))
PADDLE_HALF, 50, paddle tone half-period in samples (441 Hz at 44.1 kHz)
WALL_HALF, 100, wall tone half-period in samples (220 Hz)
SCORE_A_HALF, 40, first score tone half-period in samples
SCORE_B_HALF, 30, second score tone half-period in samples
PADDLE_DUR, 4410, paddle tone length in samples
WALL_DUR, 2205, wall tone length in samples
SCORE_DUR, 8820, length of each score tone in samples
CNT_WIDTH, 16, width of half-period and duration counters

Ports:
clock  input  1  50 MHz system clock
reset  input  1  asynchronous, active-high reset
audioClock  input  1  square wave from audio clock divider, synchronous to clock
paddleHit  input  1  single-cycle event pulse
wallHit  input  1  single-cycle event pulse
scoreEvent  input  1  single-cycle event pulse
sampleData  output  SAMPLE_WIDTH  signed two's-complement sample
sampleValid  output  1  sampleData holds an unconsumed sample
sampleReady  input  1  codec accepts sampleData when high with sampleValid
busy  output  1  high in any non-IDLE state
overrun  output  1  sticky; a sample was overwritten before acceptance

Behaviour:
- Reset state: state=IDLE; counters=0; polarity=1; audioPrev=0; sampleData=0; sampleValid=0; overrun=0.
- Tick generation:
  - audioPrev registers audioClock each cycle.
  - tick = audioClock & ~audioPrev.
  - With a 44100 divider: one tick every 1134 clocks.
- States: IDLE, PADDLE, WALL, SCORE_A, SCORE_B. busy = (state != IDLE).
- Event priority: scoreEvent > paddleHit > wallHit.
- Event acceptance:
  - An event is accepted if its priority >= current tone's priority; IDLE counts as lowest.
  - Priorities: SCORE_A/B = 3, PADDLE = 2, WALL = 1.
  - Lower-priority events are dropped, not queued.
- On accepted event (same cycle):
  - state <= PADDLE, WALL or SCORE_A.
  - halfCnt <= 0; polarity <= 1.
  - durCnt <= that tone's DUR.
  - Event-driven loads override any tick advance that cycle.
- On tick, output register:
  - sampleData is computed from pre-tick state, polarity and durCnt.
  - IDLE -> 0.
  - Otherwise mag = AMPLITUDE if durCnt > (DUR>>1), else AMPLITUDE>>1 (decay in second half).
  - sampleData = polarity ? +mag : -mag.
  - sampleValid <= 1.
- On tick in a non-IDLE state (no event that cycle):
  - If halfCnt == HALF-1: halfCnt <= 0 and polarity toggles; else halfCnt increments.
  - If durCnt == 1, transition: PADDLE/WALL -> IDLE; SCORE_A -> SCORE_B (reload durCnt=SCORE_DUR, halfCnt=0, polarity=1); SCORE_B -> IDLE.
  - Else durCnt decrements.
  - Each tone therefore emits exactly DUR samples; the first sample of a tone is +AMPLITUDE.
- Handshake:
  - Transfer occurs when sampleValid & sampleReady.
  - After a transfer, sampleValid <= 0 unless a tick occurs the same cycle; tick wins and valid stays 1 with new data.
  - sampleData is stable while sampleValid=1 and sampleReady=0, except when a tick arrives.
- Overrun:
  - Tick while sampleValid=1 and sampleReady=0: data overwritten, valid stays 1, overrun <= 1.
  - overrun is sticky until reset.
- Idle stream: in IDLE, every tick still produces a 0 sample, so the codec sees a continuous stream.
- Latency: event -> first tone sample on the next tick after the event cycle; an event coincident with a tick affects the following tick.
- Reset mid-tone: immediate return to reset state; no partial sample remains valid.

Test Plan:
- Reset, then free-run the divider (44100), sampleReady=1 -> sampleValid pulses once per 1134 clocks, sampleData=0, busy=0, overrun=0.
- Override PADDLE_HALF=2, PADDLE_DUR=6, AMPLITUDE=100; pulse paddleHit -> next 7 samples +100,+100,-100,-50,+50,+50,0; busy falls after sample 6.
- Override SCORE_A_HALF=1, SCORE_B_HALF=2, SCORE_DUR=4, AMPLITUDE=100; pulse scoreEvent -> samples +100,-100,+50,-50 then +100,+100,-50,-50 then 0.
- During WALL tone, pulse paddleHit -> restart as PADDLE, first sample +AMPLITUDE. During PADDLE, pulse wallHit -> ignored, PADDLE continues unchanged.
- Hold sampleReady=0 across two ticks -> sampleValid stays 1, sampleData shows second sample, overrun=1 and stays 1 after sampleReady returns.
- Assert reset mid-SCORE_A -> sampleValid=0, sampleData=0, busy=0 immediately; after release, first tick yields 0.
